// File: rtl/joy_map_pkg.sv
// Shared definitions for joy_map: mapping-mode encodings, Kempston bit positions,
// the pad snapshot record and the Kempston byte packer.
package joy_map_pkg;

    typedef enum logic [1:0] {
        JM_KEMPSTON  = 2'd0,
        JM_SINCLAIR1 = 2'd1,
        JM_SINCLAIR2 = 2'd2,
        JM_CURSOR    = 2'd3
    } jm_mode_e;

    localparam int KEMP_RIGHT = 0;
    localparam int KEMP_LEFT  = 1;
    localparam int KEMP_DOWN  = 2;
    localparam int KEMP_UP    = 3;
    localparam int KEMP_F1    = 4;
    localparam int KEMP_F2    = 5;
    localparam int KEMP_F3    = 6;
    localparam int KEMP_START = 7;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
        logic f1;
        logic f2;
        logic f3;
        logic start;
        logic mode;
    } pad_t;

    function automatic logic [7:0] kempston_byte(input pad_t p);
        logic [7:0] b;
        b             = 8'h00;
        b[KEMP_RIGHT] = p.right;
        b[KEMP_LEFT]  = p.left;
        b[KEMP_DOWN]  = p.down;
        b[KEMP_UP]    = p.up;
        b[KEMP_F1]    = p.f1;
        b[KEMP_F2]    = p.f2;
        b[KEMP_F3]    = p.f3;
        b[KEMP_START] = p.start;
        return b;
    endfunction

endpackage

// File: rtl/joy_map_keymatrix.sv
// joy_keymatrix: combinational keyboard-column overlay (active-high) for the
// Sinclair-1/2 and Cursor modes, from mode, pad snapshot and A[15:8] row select.
module joy_keymatrix
    import joy_map_pkg::*;
(
    input  jm_mode_e   mode,
    input  pad_t       snap,
    input  logic [7:0] a_hi,
    output logic [4:0] cols
);

    logic       fire;
    logic [4:0] row11;
    logic [4:0] row12;

    assign fire = snap.f1 | snap.f2 | snap.f3;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        row11 = 5'b00000;
        row12 = 5'b00000;
        case (mode)
            JM_SINCLAIR1: row12 = {snap.left, snap.right, snap.down, snap.up, fire};
            JM_SINCLAIR2: row11 = {fire, snap.up, snap.down, snap.right, snap.left};
            JM_CURSOR: begin
                row11 = {snap.left, 4'b0000};
                row12 = {snap.down, snap.up, snap.right, 1'b0, fire};
            end
            default: ;
        endcase
    end

    // Rows are active-low: A11 is a_hi[3], A12 is a_hi[4]; selected rows are ORed.
    assign cols = (a_hi[4] ? 5'b00000 : row12) | (a_hi[3] ? 5'b00000 : row11);

    wire unused_km = &{1'b0, a_hi[7:5], a_hi[2:0], snap.start, snap.mode};

endmodule

// File: rtl/joy_map.sv
// joy_map: snapshots the Sega pad on sync_strobe and presents it as a Kempston byte and,
// when JOYMAP_KEYS_EN is defined, a Sinclair/Cursor keyboard overlay with MODE-hold mode select.
module joy_map
    import joy_map_pkg::*;
#(
    parameter int HOLD_FRAMES = 32
) (
    input  logic       clk28,
    input  logic       rst_n,
    input  logic       sync_strobe,
    input  logic       frame_strobe,
    input  logic       joy_up,
    input  logic       joy_down,
    input  logic       joy_left,
    input  logic       joy_right,
    input  logic       joy_f1,
    input  logic       joy_f2,
    input  logic       joy_f3,
    input  logic       joy_start,
    input  logic       joy_mode,
    input  logic       mode_set_stb,
    input  logic [1:0] mode_set_val,
    input  logic [7:0] a_hi,
    output logic [1:0] map_mode,
    output logic [7:0] kempston_data,
    output logic [4:0] kb_cols_n
);

    pad_t       pad_in;
    pad_t       snap_q;
    logic [7:0] kempston_q;

    assign pad_in = '{up: joy_up, down: joy_down, left: joy_left, right: joy_right,
                      f1: joy_f1, f2: joy_f2, f3: joy_f3, start: joy_start, mode: joy_mode};

    always_ff @(posedge clk28 or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            snap_q <= '0;
        end else if (sync_strobe) begin
            snap_q <= pad_in;
        end
    end

    assign kempston_data = kempston_q;

`ifdef JOYMAP_KEYS_EN
    logic [1:0] mode_q, mode_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       lock_q, lock_d;
    logic [4:0] cols;
    logic [4:0] kb_cols_n_q;

    // A config write wins over a hold advance landing in the same cycle.
    always_comb begin
        mode_d     = mode_q;
        hold_cnt_d = hold_cnt_q;
        lock_d     = lock_q;
        if (mode_set_stb) begin
            mode_d     = mode_set_val;
            hold_cnt_d = 8'd0;
            lock_d     = snap_q.mode;
        end else if (frame_strobe) begin
            if (!snap_q.mode) begin
                hold_cnt_d = 8'd0;
                lock_d     = 1'b0;
            end else if (!lock_q && hold_cnt_q == 8'(HOLD_FRAMES - 1)) begin
                mode_d     = mode_q + 2'd1;
                hold_cnt_d = 8'd0;
                lock_d     = 1'b1;
            end else if (!lock_q) begin
                hold_cnt_d = hold_cnt_q + 8'd1;
            end
        end
    end

    joy_keymatrix u_keymatrix (
        .mode (jm_mode_e'(mode_q)),
        .snap (snap_q),
        .a_hi (a_hi),
        .cols (cols)
    );

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= 2'd0;
            hold_cnt_q  <= 8'd0;
            lock_q      <= 1'b0;
            kempston_q  <= 8'h00;
            kb_cols_n_q <= 5'b11111;
        end else begin
            mode_q      <= mode_d;
            hold_cnt_q  <= hold_cnt_d;
            lock_q      <= lock_d;
            kempston_q  <= (mode_q == JM_KEMPSTON) ? kempston_byte(snap_q) : 8'h00;
            kb_cols_n_q <= ~cols;
        end
    end

    assign map_mode  = mode_q;
    assign kb_cols_n = kb_cols_n_q;
`else
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            kempston_q <= 8'h00;
        end else begin
            kempston_q <= kempston_byte(snap_q);
        end
    end

    assign map_mode  = JM_KEMPSTON;
    assign kb_cols_n = 5'b11111;

    wire unused_cfg = &{1'b0, frame_strobe, mode_set_stb, mode_set_val, a_hi,
                        snap_q.mode, 1'(HOLD_FRAMES)};
`endif

endmodule

// File: tb/tb_joy_map.sv
// Directed bench for joy_map; expectations follow the build (JOYMAP_KEYS_EN defined or not).
module tb_joy_map;
    import joy_map_pkg::*;

`ifdef JOYMAP_KEYS_EN
    localparam bit KEYS = 1'b1;
`else
    localparam bit KEYS = 1'b0;
`endif

    logic       clk28 = 1'b0;
    logic       rst_n = 1'b0;
    logic       sync_strobe = 1'b0, frame_strobe = 1'b0;
    logic       joy_up = 1'b0, joy_down = 1'b0, joy_left = 1'b0, joy_right = 1'b0;
    logic       joy_f1 = 1'b0, joy_f2 = 1'b0, joy_f3 = 1'b0;
    logic       joy_start = 1'b0, joy_mode = 1'b0;
    logic       mode_set_stb = 1'b0;
    logic [1:0] mode_set_val = 2'd0;
    logic [7:0] a_hi = 8'hFF;
    logic [1:0] map_mode;
    logic [7:0] kempston_data;
    logic [4:0] kb_cols_n;

    int vectors = 0;
    int miscompares = 0;

    joy_map #(.HOLD_FRAMES(32)) u_dut (
        .clk28         (clk28),
        .rst_n         (rst_n),
        .sync_strobe   (sync_strobe),
        .frame_strobe  (frame_strobe),
        .joy_up        (joy_up),
        .joy_down      (joy_down),
        .joy_left      (joy_left),
        .joy_right     (joy_right),
        .joy_f1        (joy_f1),
        .joy_f2        (joy_f2),
        .joy_f3        (joy_f3),
        .joy_start     (joy_start),
        .joy_mode      (joy_mode),
        .mode_set_stb  (mode_set_stb),
        .mode_set_val  (mode_set_val),
        .a_hi          (a_hi),
        .map_mode      (map_mode),
        .kempston_data (kempston_data),
        .kb_cols_n     (kb_cols_n)
    );

    always #18 clk28 = ~clk28;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk28);
        #1;
    endtask

    task automatic pad(input logic u, d, l, r, f1, f2, f3, st, md);
        {joy_up, joy_down, joy_left, joy_right} = {u, d, l, r};
        {joy_f1, joy_f2, joy_f3, joy_start, joy_mode} = {f1, f2, f3, st, md};
    endtask

    task automatic pulse_sync();
        sync_strobe = 1'b1;
        cyc(1);
        sync_strobe = 1'b0;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            frame_strobe = 1'b1;
            cyc(1);
            frame_strobe = 1'b0;
            cyc(1);
        end
    endtask

    task automatic set_mode(input logic [1:0] v);
        mode_set_stb = 1'b1;
        mode_set_val = v;
        cyc(1);
        mode_set_stb = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #5;
        check("reset_mode", {6'd0, map_mode}, 8'h00);
        check("reset_kemp", kempston_data, 8'h00);
        check("reset_cols", {3'd0, kb_cols_n}, 8'h1F);
        cyc(1);
        rst_n = 1'b1;
        cyc(1);

        // up + f1: snapshot first, output one cycle later
        pad(1, 0, 0, 0, 1, 0, 0, 0, 0);
        pulse_sync();
        check("kemp_latency", kempston_data, 8'h00);
        cyc(1);
        check("kemp_up_f1", kempston_data, 8'h18);
        check("cols_mode0", {3'd0, kb_cols_n}, 8'h1F);

        pad(0, 0, 0, 1, 0, 0, 1, 1, 0);
        pulse_sync();
        cyc(1);
        check("kemp_r_f3_st", kempston_data, 8'hC1);

        // Sinclair-1, left on row A12
        pad(0, 0, 1, 0, 0, 0, 0, 0, 0);
        pulse_sync();
        set_mode(2'd1);
        a_hi = 8'hEF;
        cyc(1);
        check("s1_mode", {6'd0, map_mode}, KEYS ? 8'h01 : 8'h00);
        check("s1_cols_a12", {3'd0, kb_cols_n}, KEYS ? 8'h0F : 8'h1F);
        check("s1_kemp", kempston_data, KEYS ? 8'h00 : 8'h02);
        a_hi = 8'hF7;
        cyc(1);
        check("s1_cols_a11", {3'd0, kb_cols_n}, 8'h1F);

        // Sinclair-2, up + f2 on row A11
        set_mode(2'd2);
        pad(1, 0, 0, 0, 0, 1, 0, 0, 0);
        pulse_sync();
        cyc(1);
        check("s2_cols", {3'd0, kb_cols_n}, KEYS ? 8'h07 : 8'h1F);
        check("s2_kemp", kempston_data, KEYS ? 8'h00 : 8'h28);

        // Cursor, down + right, both rows selected
        set_mode(2'd3);
        pad(0, 1, 0, 1, 0, 0, 0, 0, 0);
        pulse_sync();
        a_hi = 8'hE7;
        cyc(1);
        check("cur_cols", {3'd0, kb_cols_n}, KEYS ? 8'h0B : 8'h1F);
        check("cur_kemp", kempston_data, KEYS ? 8'h00 : 8'h05);

        // MODE hold advance
        pad(0, 0, 0, 0, 0, 0, 0, 0, 0);
        pulse_sync();
        set_mode(2'd0);
        a_hi = 8'hFF;
        joy_mode = 1'b1;
        pulse_sync();
        frames(31);
        check("hold_31", {6'd0, map_mode}, 8'h00);
        frames(1);
        check("hold_32", {6'd0, map_mode}, KEYS ? 8'h01 : 8'h00);
        frames(100);
        check("hold_locked", {6'd0, map_mode}, KEYS ? 8'h01 : 8'h00);
        joy_mode = 1'b0;
        pulse_sync();
        frames(1);
        joy_mode = 1'b1;
        pulse_sync();
        frames(31);
        check("hold2_31", {6'd0, map_mode}, KEYS ? 8'h01 : 8'h00);
        frames(1);
        check("hold2_32", {6'd0, map_mode}, KEYS ? 8'h02 : 8'h00);

        // config write coinciding with the advancing frame wins
        joy_mode = 1'b0;
        pulse_sync();
        frames(1);
        joy_mode = 1'b1;
        pulse_sync();
        frames(31);
        frame_strobe = 1'b1;
        mode_set_stb = 1'b1;
        mode_set_val = 2'd3;
        cyc(1);
        frame_strobe = 1'b0;
        mode_set_stb = 1'b0;
        check("coincide_mode", {6'd0, map_mode}, KEYS ? 8'h03 : 8'h00);
`ifdef JOYMAP_KEYS_EN
        check("coincide_cnt", u_dut.hold_cnt_q, 8'h00);
`endif
        frames(40);
        check("coincide_lock", {6'd0, map_mode}, KEYS ? 8'h03 : 8'h00);
        joy_mode = 1'b0;
        pulse_sync();
        frames(1);
        joy_mode = 1'b1;
        pulse_sync();
        frames(32);
        check("wrap_3_to_0", {6'd0, map_mode}, 8'h00);

        // reset in the middle of a hold
        joy_mode = 1'b0;
        pulse_sync();
        frames(1);
        set_mode(2'd2);
        pad(1, 0, 0, 0, 0, 0, 0, 0, 1);
        pulse_sync();
        frames(20);
        a_hi = 8'hF7;
        cyc(1);
        check("pre_rst_mode", {6'd0, map_mode}, KEYS ? 8'h02 : 8'h00);
        check("pre_rst_cols", {3'd0, kb_cols_n}, KEYS ? 8'h17 : 8'h1F);
        check("pre_rst_kemp", kempston_data, KEYS ? 8'h00 : 8'h08);
        #5;
        rst_n = 1'b0;
        #1;
        check("async_rst_mode", {6'd0, map_mode}, 8'h00);
        check("async_rst_kemp", kempston_data, 8'h00);
        check("async_rst_cols", {3'd0, kb_cols_n}, 8'h1F);
        cyc(1);
        rst_n = 1'b1;
        pulse_sync();
        frames(31);
        check("post_rst_31", {6'd0, map_mode}, 8'h00);
        frames(1);
        check("post_rst_32", {6'd0, map_mode}, KEYS ? 8'h01 : 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
